// File: rtl/timer_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : timer_share_arbiter
// Purpose  : Shares one interval counter among NUM_REQ requesters. A
//            round-robin arbiter hands the counter to one requester at a
//            time, counts its interval on tick_en, then pulses its done.
// Ports    : clk       - clock
//            rst       - asynchronous, active-low reset
//            tick_en   - counter advance qualifier (prescaler strobe)
//            req       - per-requester interval request (level)
//            req_len   - packed lengths, requester i at [i*CNT_BITS +: CNT_BITS]
//            abort     - synchronous cancel of the running interval
//            gnt       - one-hot grant, high while the owner's interval runs
//            done      - one-hot, one-cycle completion pulse
//            busy      - high whenever the FSM is not idle
//            cur_count - current count of the running interval
// Revision : 1.0 - initial release
// ============================================================================
module timer_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int REQ_IDX_BITS = 2,
    parameter int CNT_BITS     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick_en,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*CNT_BITS-1:0]  req_len,
    input  logic                         abort,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic [CNT_BITS-1:0]          cur_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [REQ_IDX_BITS-1:0] c_last_idx = REQ_IDX_BITS'(NUM_REQ - 1);
    localparam logic [REQ_IDX_BITS:0]   c_num_req  = (REQ_IDX_BITS + 1)'(NUM_REQ);

    logic [1:0]              r_state;
    logic [REQ_IDX_BITS-1:0] r_winner;
    logic [REQ_IDX_BITS-1:0] r_ptr;
    logic [CNT_BITS-1:0]     r_len;
    logic [CNT_BITS-1:0]     r_cnt;
    logic [NUM_REQ-1:0]      r_gnt;
    logic [NUM_REQ-1:0]      r_done;
    logic                    r_busy;

    logic [1:0]              w_state_nxt;
    logic [REQ_IDX_BITS-1:0] w_winner_nxt;
    logic [REQ_IDX_BITS-1:0] w_ptr_nxt;
    logic [CNT_BITS-1:0]     w_len_nxt;
    logic [CNT_BITS-1:0]     w_cnt_nxt;
    logic [NUM_REQ-1:0]      w_gnt_nxt;
    logic [NUM_REQ-1:0]      w_done_nxt;

    logic                    w_found;
    logic [REQ_IDX_BITS-1:0] w_sel;
    logic [REQ_IDX_BITS:0]   w_sum;
    logic [REQ_IDX_BITS-1:0] w_idx;
    logic [CNT_BITS-1:0]     w_len_sel;
    logic [REQ_IDX_BITS-1:0] w_ptr_after;
    logic [CNT_BITS-1:0]     w_len_arr [NUM_REQ];

    // Unpack the flat length bus so it can be indexed by the winner.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
            assign w_len_arr[gi] = req_len[gi*CNT_BITS +: CNT_BITS];
        end
    endgenerate

    // Round-robin scan starting at the pointer. ptr and the offset are both
    // below NUM_REQ, so one conditional subtraction gives the modulo.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (REQ_IDX_BITS + 1)'(k);
            if (w_sum >= c_num_req) begin
                w_sum = w_sum - c_num_req;
            end
            w_idx = w_sum[REQ_IDX_BITS-1:0];
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // A zero length still costs one tick so the counter never underflows.
    assign w_len_sel   = (w_len_arr[w_sel] == '0) ? CNT_BITS'(1) : w_len_arr[w_sel];
    assign w_ptr_after = (r_winner == c_last_idx) ? '0 : r_winner + REQ_IDX_BITS'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_winner_nxt = r_winner;
        w_ptr_nxt    = r_ptr;
        w_len_nxt    = r_len;
        w_cnt_nxt    = r_cnt;
        w_gnt_nxt    = r_gnt;
        w_done_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                w_cnt_nxt = '0;
                if (w_found) begin
                    w_state_nxt  = S_RUN;
                    w_winner_nxt = w_sel;
                    w_len_nxt    = w_len_sel;
                    w_gnt_nxt    = NUM_REQ'(1) << w_sel;
                end
            end
            S_RUN: begin
                // abort has priority over a tick in the same cycle
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_after;
                end else if (tick_en) begin
                    if (r_cnt == r_len - CNT_BITS'(1)) begin
                        w_state_nxt = S_DONE;
                        w_gnt_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = NUM_REQ'(1) << r_winner;
                        w_ptr_nxt   = w_ptr_after;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_BITS'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_winner <= '0;
            r_ptr    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_winner <= w_winner_nxt;
            r_ptr    <= w_ptr_nxt;
            r_len    <= w_len_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign busy      = r_busy;
    assign cur_count = r_cnt;

endmodule
`default_nettype wire

// File: doc/timer_share_arbiter.md
Name: timer_share_arbiter

Overview:
- Shares one interval counter among NUM_REQ requesters.
- Each requester asks for a timed interval of req_len ticks. A round-robin arbiter grants the counter to one requester at a time, counts the interval on tick_en, then pulses that requester's done.
- Sits between the control FSMs that need delays and the single counter resource, so each FSM does not need its own counter.

Parameters:
- NUM_REQ, 4, number of requesters
- REQ_IDX_BITS, 2, width of the internal winner index and round-robin pointer; must satisfy 2**REQ_IDX_BITS >= NUM_REQ
- CNT_BITS, 8, width of the interval length and the counter

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- tick_en  input  1  counter advance qualifier (prescaler strobe); the counter moves only when high
- req  input  NUM_REQ  per-requester interval request, level
- req_len  input  NUM_REQ*CNT_BITS  packed lengths; requester i uses bits [i*CNT_BITS +: CNT_BITS]
- abort  input  1  synchronous cancel of the interval in progress
- gnt  output  NUM_REQ  one-hot grant, high while the owner's interval runs
- done  output  NUM_REQ  one-hot, one-cycle pulse at interval completion
- busy  output  1  high when state != IDLE
- cur_count  output  CNT_BITS  current count of the running interval

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=0, done=0, busy=0, cur_count=0, rr pointer=0, latched length=0.
- FSM states: IDLE, RUN, DONE. All outputs are registered.

IDLE:
- If req != 0, select the first asserted req scanning ptr, ptr+1, ... mod NUM_REQ.
- Latch the winner index and its req_len slice, clear the counter, and go to RUN.
- A latched length of 0 is treated as 1.
- If req == 0, stay in IDLE.

RUN:
- gnt[winner]=1.
- On tick_en=1: if cur_count == len-1, go to DONE; else cur_count increments by 1.
- tick_en=0 holds cur_count.
- req and req_len are not re-sampled in RUN. Dropping req mid-interval does not stop the interval.
- abort=1 wins over tick_en: go to IDLE, gnt=0, no done pulse, cur_count=0, ptr=winner+1 mod NUM_REQ.

DONE (exactly one cycle):
- done[winner]=1, gnt=0, cur_count=0, ptr=winner+1 mod NUM_REQ, then IDLE.
- abort in IDLE or DONE is ignored.

Latency, with req rising while in IDLE at cycle 0 and tick_en held 1:
- gnt is high in cycles 1..L.
- done pulses in cycle L+1.
- IDLE is reached in cycle L+2.
- The earliest next gnt is in cycle L+3.

Fairness and other rules:
- A requester that keeps req high after done is re-eligible, but ranks last behind all others.
- The counter never wraps; the maximum interval is 2**CNT_BITS-1 ticks, with len=0 mapped to 1.
- Simultaneous requests are resolved only by the rr pointer, never by fixed priority.
- gnt and done are never both nonzero in the same cycle.
- Reset asserted mid-interval returns to the reset values immediately, with no done pulse.

Test Plan:
- Single request: req=0001, req_len[0]=5, tick_en=1 → gnt=0001 cycles 1-5; cur_count 0,1,2,3,4; done=0001 in cycle 6 only; busy low in cycle 7.
- Round-robin: req=1111 held, all lengths=2 → grant order 0,1,2,3,0; each grant lasts 2 cycles, with a 2-cycle gap (DONE, IDLE) between grants.
- tick_en gating: req=0010, len=3, tick_en pulsed every 3rd cycle → done only after the 3rd tick; cur_count holds between ticks; gnt stays 0010 throughout.
- Length 0 and the maximum: len=0 → done after 1 tick. len=255 (CNT_BITS=8) → done after 255 ticks, and cur_count peaks at 254 without wrapping.
- Abort and mid-interval changes:
  - req=0100, len=10; abort at cur_count=4 → gnt=0 next cycle, done never pulses, ptr=3.
  - Second run: dropping req and changing req_len mid-interval → the interval still completes with the original length.
- Async reset: rst low while in RUN with cur_count=7 → gnt, done, busy, cur_count all 0 immediately. After release, req=1001 → requester 0 is granted first (ptr=0).
